// File: rtl/board_text_renderer.sv
// Streams an NxN tile board plus score as ASCII text,
// one byte per valid/ready handshake, with bit-serial BCD conversion.
module board_text_renderer #(
  parameter int SIZE         = 4,
  parameter int TILE_W       = 20,
  parameter int DIGITS       = 4,
  parameter int SCORE_W      = 21,
  parameter int SCORE_DIGITS = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SIZE*SIZE*TILE_W-1:0]   board,
  input  logic [SCORE_W-1:0]            score,
  input  logic                          start,
  output logic                          busy,
  output logic [7:0]                    char_out,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic                          done
);

  localparam int CW   = DIGITS + 3;
  localparam int LW   = SIZE * CW + 1;
  localparam int NL   = 4 * SIZE + 1;
  localparam int TRL  = SCORE_DIGITS + 11;
  localparam int ND   = ((DIGITS > SCORE_DIGITS) ? DIGITS : SCORE_DIGITS) + 1;
  localparam int BW   = 4 * ND;
  localparam int VW   = (TILE_W > SCORE_W) ? TILE_W : SCORE_W;
  localparam int CMAX = (LW + 1 > TRL - 1) ? LW + 1 : TRL - 1;
  localparam int CLW  = $clog2(CMAX + 1);
  localparam int LNW  = $clog2(NL + 1);
  localparam int OFW  = $clog2(CW);
  localparam int CEW  = $clog2(SIZE + 1);
  localparam int CTW  = $clog2(VW + 1);
  localparam int BVW  = SIZE * SIZE * TILE_W;

  localparam logic [55:0] PFX = "score: ";

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_CONV,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [LNW-1:0]     line_q, line_d;
  logic [CLW-1:0]     col_q, col_d;
  logic [OFW-1:0]     off_q, off_d;
  logic [CEW-1:0]     cell_q, cell_d;
  logic [BVW-1:0]     board_q;
  logic [SCORE_W-1:0] score_q;
  logic [VW-1:0]      sh_q, ld_v;
  logic [CTW-1:0]     cnt_q, ld_cnt;
  logic [BW-1:0]      bcd_q, bcd_d, adj;
  logic               ovf_q, ovf_d;
  logic [7:0]         char_q, ch_d;
  logic               valid_q, busy_q, done_q;

  logic               in_tr, conv_t, conv_s, last_c;
  logic               t_ovf, s_ovf;
  logic [TILE_W-1:0]  tile_v;
  logic [3:0]         dig;
  int                 tidx, pl, pc, po, dp;

  assign busy       = busy_q;
  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign done       = done_q;

  assign in_tr  = (int'(line_q) == NL);
  assign conv_t = !in_tr && (line_q[1:0] == 2'd2) &&
                  (int'(off_q) == 0) && (int'(cell_q) < SIZE);
  assign conv_s = in_tr && (int'(col_q) == 8);
  assign last_c = in_tr && (int'(col_q) == TRL - 1);

  assign t_ovf = ovf_q | (|(bcd_q >> (4 * DIGITS)));
  assign s_ovf = ovf_q | (|(bcd_q >> (4 * SCORE_DIGITS)));

  // step the text cursor to the following character
  always_comb begin
    line_d = line_q;
    col_d  = col_q + CLW'(1);
    off_d  = off_q;
    cell_d = cell_q;
    if (!in_tr) begin
      if (int'(col_q) == LW + 1) begin
        line_d = line_q + LNW'(1);
        col_d  = '0;
        off_d  = '0;
        cell_d = '0;
      end else if (int'(off_q) == CW - 1) begin
        off_d  = '0;
        cell_d = cell_q + CEW'(1);
      end else begin
        off_d  = off_q + OFW'(1);
      end
    end
  end

  // pick the value to convert and left-align it in the shifter
  always_comb begin
    tidx = int'(line_q >> 2) * SIZE + int'(cell_q);
    if (tidx >= SIZE * SIZE) tidx = 0;
    tile_v = board_q[tidx*TILE_W +: TILE_W];
    ld_v   = '0;
    if (conv_t) begin
      ld_v[VW-1 -: TILE_W] = tile_v;
      ld_cnt = CTW'(TILE_W);
    end else begin
      ld_v[VW-1 -: SCORE_W] = score_q;
      ld_cnt = CTW'(SCORE_W);
    end
  end

  // one double-dabble step; bits lost off the top flag overflow
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[BW-2:0], sh_q[VW-1]};
    ovf_d = ovf_q | adj[BW-1];
  end

  // character at the cursor (next position, or current one after CONV)
  always_comb begin
    if (state_q == S_CONV) begin
      pl = int'(line_q);
      pc = int'(col_q);
      po = int'(off_q);
    end else begin
      pl = int'(line_d);
      pc = int'(col_d);
      po = int'(off_d);
    end
    ch_d = 8'h20;
    dig  = 4'd0;
    dp   = 0;
    if (pl == NL) begin
      if (pc == 0) begin
        ch_d = 8'h0D;
      end else if (pc == 1) begin
        ch_d = 8'h0A;
      end else if (pc < 9) begin
        ch_d = PFX[8*(8-pc) +: 8];
      end else if (pc < 9 + SCORE_DIGITS) begin
        dp   = SCORE_DIGITS + 8 - pc;
        dig  = bcd_q[4*dp +: 4];
        ch_d = s_ovf ? 8'h2A : {4'h3, dig};
      end else if (pc == 9 + SCORE_DIGITS) begin
        ch_d = 8'h0D;
      end else begin
        ch_d = 8'h0A;
      end
    end else if (pc == LW) begin
      ch_d = 8'h0D;
    end else if (pc == LW + 1) begin
      ch_d = 8'h0A;
    end else if (pl % 4 == 0) begin
      ch_d = 8'h2D;
    end else if (po == 0) begin
      ch_d = 8'h7C;
    end else if (pl % 4 != 2 || po == 1 || po == CW - 1) begin
      ch_d = 8'h20;
    end else begin
      dp  = DIGITS + 1 - po;
      dig = bcd_q[4*dp +: 4];
      if (t_ovf) begin
        ch_d = 8'h2A;
      end else if ((bcd_q >> (4 * dp)) == '0) begin
        ch_d = 8'h20;
      end else begin
        ch_d = {4'h3, dig};
      end
    end
  end

  // frame sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      col_q   <= '0;
      off_q   <= '0;
      cell_q  <= '0;
      board_q <= '0;
      score_q <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            board_q <= board;
            score_q <= score;
            line_q  <= '0;
            col_q   <= '0;
            off_q   <= '0;
            cell_q  <= '0;
            char_q  <= 8'h2D;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (char_ready) begin
            line_q <= line_d;
            col_q  <= col_d;
            off_q  <= off_d;
            cell_q <= cell_d;
            unique case (1'b1)
              last_c: begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              conv_t, conv_s: begin
                valid_q <= 1'b0;
                sh_q    <= ld_v;
                cnt_q   <= ld_cnt;
                bcd_q   <= '0;
                ovf_q   <= 1'b0;
                state_q <= S_CONV;
              end
              default: begin
                char_q <= ch_d;
              end
            endcase
          end
        end
        S_CONV: begin
          if (cnt_q != '0) begin
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - CTW'(1);
          end else begin
            char_q  <= ch_d;
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
